// File: rtl/pll_cfg_pkg.sv
// rtl/pll_cfg_pkg.sv - shared state type, register map and fixed PLL words for pll_cfg_ctrl
package pll_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_WAIT_LOCK = 2'd2
  } state_t;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C0    = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;

  localparam logic [31:0] MODE_WORD  = 32'h0000_0000;
  localparam logic [31:0] M_WORD     = 32'h0000_0404;
  localparam logic [31:0] N_WORD     = 32'h0001_0000;
  localparam logic [31:0] C0_WORD    = 32'h0000_0404;
  localparam logic [31:0] START_WORD = 32'h0000_0000;

  localparam logic [2:0]  LAST_IDX     = 3'd5;
  localparam logic [19:0] BLANK_CYCLES = 20'd16;
  localparam logic [19:0] TIMER_MAX    = 20'hF_FFFF;

endpackage

// File: rtl/pll_cfg_rom.sv
// rtl/pll_cfg_rom.sv - write sequence table: step index and profile select to address/data
module pll_cfg_rom
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] K_NTSC = 32'h9745BF27,
  parameter logic [31:0] K_PAL  = 32'h83365882
) (
  input  logic [2:0]  idx,
  input  logic        sel,
  output logic [5:0]  address,
  output logic [31:0] writedata
);

  always_comb begin
    address   = 6'h00;
    writedata = 32'h0;
    case (idx)
      3'd0: begin address = ADDR_MODE;  writedata = MODE_WORD;  end
      3'd1: begin address = ADDR_M;     writedata = M_WORD;     end
      3'd2: begin address = ADDR_N;     writedata = N_WORD;     end
      3'd3: begin address = ADDR_C0;    writedata = C0_WORD;    end
      3'd4: begin address = ADDR_K;     writedata = sel ? K_PAL : K_NTSC; end
      3'd5: begin address = ADDR_START; writedata = START_WORD; end
      default: begin address = 6'h00;   writedata = 32'h0;      end
    endcase
  end

endmodule

// File: rtl/pll_cfg_ctrl.sv
// rtl/pll_cfg_ctrl.sv - PLL reconfiguration sequencer: six management writes, then lock wait with timeout
module pll_cfg_ctrl
  import pll_cfg_pkg::*;
#(
  parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000,
  parameter logic [31:0] K_NTSC       = 32'h9745BF27,
  parameter logic [31:0] K_PAL        = 32'h83365882
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic        cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cur_sel,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  state_t      state, state_n;
  logic [2:0]  idx;
  logic        sel_q, pend_q, pend_sel_q;
  logic [19:0] timer;
  logic        lock_meta, lock_sync;
  logic        accept, accept_sel, wr_acc, fin_ok, fin_to;
  logic [5:0]  rom_address;
  logic [31:0] rom_writedata;

  pll_cfg_rom #(.K_NTSC(K_NTSC), .K_PAL(K_PAL)) u_rom (
    .idx       (idx),
    .sel       (sel_q),
    .address   (rom_address),
    .writedata (rom_writedata)
  );

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    accept_sel = cfg_sel;
    wr_acc     = 1'b0;
    fin_ok     = 1'b0;
    fin_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A fresh request overrides whatever was parked while busy.
        if (cfg_req || pend_q) begin
          accept     = 1'b1;
          accept_sel = cfg_req ? cfg_sel : pend_sel_q;
          state_n    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_acc = !mgmt_waitrequest;
        if (wr_acc && idx == LAST_IDX) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Early lock is ignored: the PLL may still report the old lock before dropping.
        if (timer >= BLANK_CYCLES && lock_sync) begin
          fin_ok  = 1'b1;
          state_n = ST_IDLE;
        end else if (timer == LOCK_TIMEOUT - 20'd1) begin
          fin_to  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      sel_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_sel_q <= 1'b0;
      timer      <= 20'd0;
      lock_meta  <= 1'b0;
      lock_sync  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cur_sel    <= 1'b0;
    end else begin
      state     <= state_n;
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
      done      <= fin_ok;
      if (accept) begin
        sel_q  <= accept_sel;
        idx    <= 3'd0;
        err    <= 1'b0;
        pend_q <= 1'b0;
      end else if (state != ST_IDLE && cfg_req) begin
        pend_q     <= 1'b1;
        pend_sel_q <= cfg_sel;
      end
      if (wr_acc) idx <= idx + 3'd1;
      if (state != ST_WAIT_LOCK) timer <= 20'd0;
      else if (timer != TIMER_MAX) timer <= timer + 20'd1;
      if (fin_ok) cur_sel <= sel_q;
      if (fin_to) err <= 1'b1;
    end
  end

  assign busy           = (state != ST_IDLE);
  assign mgmt_write     = (state == ST_WRITE);
  assign mgmt_address   = (state == ST_WRITE) ? rom_address   : 6'h00;
  assign mgmt_writedata = (state == ST_WRITE) ? rom_writedata : 32'h0;

endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb/tb_pll_cfg_ctrl.sv - self-checking bench for pll_cfg_ctrl against a transaction-level model
module tb_pll_cfg_ctrl;

  localparam logic [19:0] TO = 20'd200;
  localparam logic [31:0] KN = 32'h9745BF27;
  localparam logic [31:0] KP = 32'h83365882;

  logic clk = 1'b0, rst = 1'b1, cfg_req = 1'b0, cfg_sel = 1'b0;
  logic mgmt_waitrequest = 1'b0, pll_locked = 1'b0;
  logic busy, done, err, cur_sel, mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int start_cyc = -1, done_cyc = -1, err_cyc = -1, done_cnt = 0, a4_cnt = 0;
  logic err_prev = 1'b0;
  logic [5:0]  log_a[$];
  logic [31:0] log_d[$];
  int          log_c[$];
  logic [5:0]  exp_a [6] = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h07, 6'h02};

  logic m_busy = 0, m_done = 0, m_err = 0, m_cur = 0, m_pend = 0, m_psel = 0, m_sel = 0;
  logic l1 = 0, l2 = 0;
  int   m_wait = -1;
  logic [5:0]  q_a[$];
  logic [31:0] q_d[$];

  bit stall_en = 0;
  int stall_n = 0;

  always #5 clk = ~clk;

  pll_cfg_ctrl #(.LOCK_TIMEOUT(TO), .K_NTSC(KN), .K_PAL(KP)) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .busy(busy), .done(done), .err(err), .cur_sel(cur_sel),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pre-edge inputs decide the next state; outputs compared 1 time unit after the edge.
  always @(posedge clk) begin
    logic lock_s;
    cyc++;
    if (!rst && mgmt_write && !mgmt_waitrequest) begin
      log_a.push_back(mgmt_address);
      log_d.push_back(mgmt_writedata);
      log_c.push_back(cyc);
      if (mgmt_address == 6'h02) start_cyc = cyc;
    end
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_err = 0; m_cur = 0; m_pend = 0; m_psel = 0; m_sel = 0;
      l1 = 0; l2 = 0; m_wait = -1;
      q_a.delete(); q_d.delete();
    end else begin
      lock_s = l2; l2 = l1; l1 = pll_locked;
      if (m_busy) begin
        if (cfg_req) begin m_pend = 1; m_psel = cfg_sel; end
        if (q_a.size() > 0) begin
          if (!mgmt_waitrequest) begin
            void'(q_a.pop_front());
            void'(q_d.pop_front());
            if (q_a.size() == 0) m_wait = 0;
          end
        end else if (m_wait >= 16 && lock_s) begin
          m_done = 1; m_cur = m_sel; m_busy = 0; m_wait = -1;
        end else if (m_wait == int'(TO) - 1) begin
          m_err = 1; m_busy = 0; m_wait = -1;
        end else begin
          m_wait++;
        end
      end else if (cfg_req || m_pend) begin
        m_sel = cfg_req ? cfg_sel : m_psel;
        m_pend = 0; m_err = 0; m_busy = 1;
        q_a = '{6'h00, 6'h04, 6'h03, 6'h05, 6'h07, 6'h02};
        q_d = '{32'h0, 32'h404, 32'h10000, 32'h404, (m_sel ? KP : KN), 32'h0};
      end
    end
    #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("cur_sel", cur_sel, m_cur);
    chk("mgmt_write", mgmt_write, (q_a.size() > 0) ? 1 : 0);
    chk("mgmt_address", mgmt_address, (q_a.size() > 0) ? q_a[0] : 6'h00);
    chk("mgmt_writedata", mgmt_writedata, (q_d.size() > 0) ? q_d[0] : 32'h0);
    chk("done_err_excl", done & err, 0);
    if (done) begin done_cyc = cyc; done_cnt++; end
    if (err && !err_prev) err_cyc = cyc;
    err_prev = err;
    if (mgmt_write && mgmt_address == 6'h04) a4_cnt++;
  end

  always @(negedge clk) begin
    if (!stall_en) stall_n = 0;
    if (stall_en && mgmt_write && mgmt_address == 6'h04 && stall_n < 3) begin
      mgmt_waitrequest = 1'b1;
      stall_n++;
    end else begin
      mgmt_waitrequest = 1'b0;
    end
  end

  task automatic req(input logic sel);
    @(negedge clk); cfg_req = 1'b1; cfg_sel = sel;
    @(negedge clk); cfg_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    chk(name, busy, 0);
  endtask

  task automatic clear_logs();
    log_a.delete(); log_d.delete(); log_c.delete(); a4_cnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_mgmt_write", mgmt_write, 0);
    chk("reset_cur_sel", cur_sel, 0);

    // PAL, no stall, lock after 100 cycles
    clear_logs();
    req(1'b1);
    repeat (100) @(negedge clk);
    pll_locked = 1'b1;
    wait_idle(300, "pal_idle_timeout");
    chk("pal_write_count", log_a.size(), 6);
    for (int i = 0; i < 6; i++) chk("pal_addr_order", log_a[i], exp_a[i]);
    chk("pal_consecutive", log_c[5] - log_c[0], 5);
    chk("pal_k_data", log_d[4], KP);
    chk("pal_cur_sel", cur_sel, 1);
    chk("pal_done_cnt", done_cnt, 1);

    // NTSC, 3-cycle stall on M write, lock held high throughout
    clear_logs();
    stall_en = 1;
    req(1'b0);
    wait_idle(300, "stall_idle_timeout");
    stall_en = 0;
    chk("stall_addr4_cycles", a4_cnt, 4);
    chk("stall_write_count", log_a.size(), 6);
    for (int i = 0; i < 6; i++) chk("stall_addr_order", log_a[i], exp_a[i]);
    chk("stall_k_data", log_d[4], KN);
    chk("blank_min_16", (done_cyc - start_cyc >= 16) ? 1 : 0, 1);
    chk("stall_cur_sel", cur_sel, 0);

    // Lock never arrives: timeout
    pll_locked = 1'b0;
    clear_logs();
    req(1'b1);
    wait_idle(400, "timeout_idle_timeout");
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_cur_sel", cur_sel, 0);
    chk("timeout_latency", err_cyc - start_cyc, 200);

    // Two requests while writing: one extra sequence, newest select wins
    pll_locked = 1'b1;
    clear_logs();
    begin
      int d0;
      d0 = done_cnt;
      req(1'b1);
      chk("err_cleared", err, 0);
      @(negedge clk); cfg_req = 1'b1; cfg_sel = 1'b0;
      @(negedge clk); cfg_req = 1'b0;
      @(negedge clk); cfg_req = 1'b1; cfg_sel = 1'b0;
      @(negedge clk); cfg_req = 1'b0;
      wait_idle(300, "pend_first_timeout");
      repeat (3) @(negedge clk);
      wait_idle(300, "pend_second_timeout");
      repeat (40) @(negedge clk);
      chk("pend_write_count", log_a.size(), 12);
      chk("pend_k_first", log_d[4], KP);
      chk("pend_k_second", log_d[10], KN);
      chk("pend_done_cnt", done_cnt - d0, 2);
      chk("pend_cur_sel", cur_sel, 0);
    end

    // Reset during the C0 write, then a clean sequence
    req(1'b1);
    begin
      int n = 0;
      while (!(mgmt_write && mgmt_address == 6'h05) && n < 20) begin @(negedge clk); n++; end
      chk("rst_reach_c0", mgmt_address, 6'h05);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mgmt_write", mgmt_write, 0);
    chk("rst_busy", busy, 0);
    clear_logs();
    req(1'b1);
    wait_idle(300, "rst_rerun_timeout");
    chk("rst_rerun_count", log_a.size(), 6);
    chk("rst_rerun_first_addr", log_a[0], 6'h00);
    chk("rst_rerun_k", log_d[4], KP);
    chk("rst_rerun_cur_sel", cur_sel, 1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
